// File: rtl/rgb_gray_stage.sv
// RGB-to-luma stage: a 2-stage multiply/sum pipeline feeding a show-ahead FIFO toward the Sobel core.
// Define GRAY_ROUND_EN to round half-up instead of truncating the luma sum.
module rgb_gray_stage #(
    parameter int MAX_PIXEL_BITS = 24,
    parameter int GRAY_BITS      = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [MAX_PIXEL_BITS-1:0]         px_rgb_i,
    input  logic                              px_rdy_i,
    output logic [GRAY_BITS-1:0]              px_gray_o,
    output logic                              px_gray_valid_o,
    input  logic                              px_gray_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o,
    output logic                              overflow_o
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [15:0]          prodR_q, prodG_q, prodB_q;
    logic [15:0]          prodR_d, prodG_d, prodB_d;
    logic                 v1_q;
    logic [16:0]          sumRaw, sumAdj;
    logic [8:0]           unusedSumBits;
    logic [GRAY_BITS-1:0] gray_d;

    logic [GRAY_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 push, pop, full, pushOk;

    // Coefficients 77/150/29 sum to 256, so the luma lands in bits [15:8] of the sum.
    always_comb begin
        prodR_d = 16'(px_rgb_i[23:16]) * 16'd77;
        prodG_d = 16'(px_rgb_i[15:8])  * 16'd150;
        prodB_d = 16'(px_rgb_i[7:0])   * 16'd29;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prodR_q <= '0;
            prodG_q <= '0;
            prodB_q <= '0;
            v1_q    <= 1'b0;
        end else begin
            v1_q <= px_rdy_i;
            if (px_rdy_i) begin
                prodR_q <= prodR_d;
                prodG_q <= prodG_d;
                prodB_q <= prodB_d;
            end
        end
    end

    always_comb begin
        sumRaw = {1'b0, prodR_q} + {1'b0, prodG_q} + {1'b0, prodB_q};
`ifdef GRAY_ROUND_EN
        sumAdj = sumRaw + 17'd128;
`else
        sumAdj = sumRaw;
`endif
        gray_d        = sumAdj[15:8];
        unusedSumBits = {sumAdj[16], sumAdj[7:0]};
    end

    // A push into a full FIFO still succeeds when the head is popped on the same edge.
    always_comb begin
        push       = v1_q;
        pop        = px_gray_valid_o & px_gray_ready_i;
        full       = (level_q == LVL_W'(FIFO_DEPTH));
        pushOk     = push & (~full | pop);
        wrPtr_d    = pushOk ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d    = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        level_d    = level_q;
        if (pushOk && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !pushOk) begin
            level_d = level_q - LVL_W'(1);
        end
        overflow_d = overflow_q | (push & full & ~pop);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pushOk) begin
                mem_q[wrPtr_q] <= gray_d;
            end
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    assign px_gray_o       = mem_q[rdPtr_q];
    assign px_gray_valid_o = (level_q != '0);
    assign fifo_level_o    = level_q;
    assign overflow_o      = overflow_q;

endmodule
